fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, the instruction presented when no valid fetch data exists.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port StallF  input  1  hazard-unit stall; holds the PC and the current fetch.
REQ-006 SHALL have port pc_src_D  input  1  branch/jump taken, resolved in decode.
REQ-007 SHALL have port pc_branch_D  input  32  redirect target from decode.
REQ-008 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port imem_addr  output  32  word-aligned read address.
REQ-010 SHALL have port imem_ready  input  1  read data valid this cycle.
REQ-011 SHALL have port imem_rdata  input  32  read data.
REQ-012 SHALL have port pc_plus_four_F  output  32  PC+4 of the instruction on instruction_F.
REQ-013 SHALL have port instruction_F  output  32  fetched instruction, feeding the IF/ID register.
REQ-014 SHALL have port fetch_busy  output  1  stall request to the hazard unit while memory is outstanding.
REQ-015 SHALL have port fetch_misaligned  output  1  sticky flag for a redirect target with nonzero bits [1:0].
REQ-016 SHALL have port fetch_count  output  32  count of instructions handed to decode.

Function
REQ-017 SHALL implement a two-state FSM: FETCH (request outstanding) and HELD (word captured, waiting for StallF to drop).
REQ-018 In FETCH, SHALL drive imem_req=1, imem_addr=pc and fetch_busy=!imem_ready.
REQ-019 In FETCH, SHALL drive instruction_F = imem_ready ? imem_rdata : NOP_WORD.
REQ-020 In HELD, SHALL drive imem_req=0, fetch_busy=0, instruction_F=held buffer.
REQ-021 In both states, SHALL drive pc_plus_four_F = pc + 32'd4, a 32-bit sum with wrap-around and no carry out (32'hFFFF_FFFC gives 32'h0000_0000).
REQ-022 SHALL define next_pc = pc_src_D ? {pc_branch_D[31:2],2'b00} : pc+4.
REQ-023 An advance SHALL happen in FETCH when imem_ready=1 and StallF=0: pc<=next_pc, stay in FETCH, fetch_count+1.
REQ-024 FETCH with imem_ready=1 and StallF=1 SHALL capture buffer<=imem_rdata, go to HELD, and leave pc unchanged.
REQ-025 FETCH with imem_ready=0 SHALL hold pc and state, regardless of StallF and pc_src_D.
REQ-026 HELD with StallF=0 SHALL advance: pc<=next_pc, go to FETCH, fetch_count+1.
REQ-027 HELD with StallF=1 SHALL hold state; imem_ready/imem_rdata are ignored in HELD.
REQ-028 pc_src_D and pc_branch_D SHALL be sampled only on an advance edge.
REQ-029 An advance with pc_src_D=1 and pc_branch_D[1:0]!=0 SHALL set fetch_misaligned, which stays set until reset.
REQ-030 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 Each outstanding request SHALL keep imem_addr stable from its first cycle until imem_ready.

Reset
REQ-032 reset=1 at an edge SHALL set pc=RESET_PC, state=FETCH, buffer=NOP_WORD, fetch_misaligned=0 and fetch_count=0, overriding all other inputs.
REQ-033 Reset asserted mid-request or in HELD SHALL discard the word in flight; the first post-reset request SHALL address RESET_PC.
REQ-034 Outputs SHALL settle to their reset values in the cycle after the reset edge: imem_req=1, imem_addr=RESET_PC, pc_plus_four_F=RESET_PC+4, fetch_busy=!imem_ready.

Verification
REQ-035 Zero-wait memory (imem_ready=1 always), StallF=0, no branches, 4 cycles after reset -> imem_addr 0,4,8,C; fetch_count=4; fetch_busy=0 throughout.
REQ-036 imem_ready low 2 cycles on address 8 -> fetch_busy=1 for 2 cycles, instruction_F=NOP_WORD; then 32'h2108_0001 appears with pc_plus_four_F=32'hC.
REQ-037 StallF=1 as 32'hAAAA_5555 arrives at address 4 -> HELD, imem_req=0, instruction_F=32'hAAAA_5555 held 3 cycles; on release, next imem_addr=8.
REQ-038 On an advance with pc_src_D=1, pc_branch_D=32'h0000_0102 -> next imem_addr=32'h0000_0100 and fetch_misaligned=1, still 1 after 10 further cycles.
REQ-039 reset asserted while imem_ready=0 on address 32'h40, with RESET_PC=32'h0040_0000 -> next imem_addr=32'h0040_0000 and fetch_count=0.
REQ-040 pc forced near 32'hFFFF_FFFC via branch, then advanced -> pc_plus_four_F=0 and the following imem_addr=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory read channel between the fetch stage and the memory.
//   imem_req   : read request, held while a fetch is outstanding
//   imem_addr  : word-aligned read address, stable until imem_ready
//   imem_ready : read data valid this cycle
//   imem_rdata : read data
// master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface : fetch_stage_if

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch with a variable-latency instruction memory. A request is
// kept outstanding on the current PC until the memory answers. If decode is
// stalled when the word arrives, the word is parked in a buffer (HELD) and the
// memory is left idle until the stall drops.
//
// Ports
//   clock            : single clock, rising edge
//   reset            : synchronous, active-high
//   StallF           : hazard-unit stall, holds PC and the current fetch
//   pc_src_D         : branch/jump taken (from decode)
//   pc_branch_D      : redirect target (from decode)
//   imem             : instruction-memory read channel (master side)
//   pc_plus_four_F   : PC+4 of the instruction on instruction_F
//   instruction_F    : fetched instruction for the IF/ID register
//   fetch_busy       : stall request while memory is outstanding
//   fetch_misaligned : sticky flag, redirect target had nonzero bits [1:0]
//   fetch_count      : number of instructions handed to decode (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          StallF,
  input  logic          pc_src_D,
  input  logic [31:0]   pc_branch_D,
  fetch_stage_if.master imem,
  output logic [31:0]   pc_plus_four_F,
  output logic [31:0]   instruction_F,
  output logic          fetch_busy,
  output logic          fetch_misaligned,
  output logic [31:0]   fetch_count
);

  typedef enum logic {
    S_FETCH = 1'b0,   // request outstanding on pc_q
    S_HELD  = 1'b1    // word captured in buf_q, waiting for StallF to drop
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic        misaligned_q;
  logic [31:0] count_q;

  logic [31:0] pc_plus_four;
  logic [31:0] next_pc;
  logic        advance;
  logic        capture;

  assign pc_plus_four = pc_q + 32'd4;   // 32-bit wrap, carry discarded
  assign next_pc      = pc_src_D ? {pc_branch_D[31:2], 2'b00} : pc_plus_four;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // With imem_ready low nothing moves, whatever StallF or pc_src_D say.
        if (imem.imem_ready) begin
          if (StallF) begin
            capture = 1'b1;
            state_d = S_HELD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_HELD: begin
        // Memory is idle here; imem_ready/imem_rdata are ignored.
        if (!StallF) begin
          advance = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;   // pc_q only moves on an advance, so the address is stable
    fetch_busy     = 1'b0;
    instruction_F  = NOP_WORD;
    unique case (state_q)
      S_FETCH: begin
        imem.imem_req = 1'b1;
        fetch_busy    = !imem.imem_ready;
        instruction_F = imem.imem_ready ? imem.imem_rdata : NOP_WORD;
      end
      S_HELD: begin
        instruction_F = buf_q;
      end
      default: ;
    endcase
  end

  assign pc_plus_four_F   = pc_plus_four;
  assign fetch_misaligned = misaligned_q;
  assign fetch_count      = count_q;

  // ---------------------------------------------------------------------------
  // Datapath registers: PC, held word, misaligned flag, handoff counter.
  // Redirect inputs are only looked at on an advance edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      buf_q        <= NOP_WORD;
      misaligned_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      if (capture) buf_q <= imem.imem_rdata;
      if (advance) begin
        pc_q    <= next_pc;
        count_q <= count_q + 32'd1;
        if (pc_src_D && (pc_branch_D[1:0] != 2'b00)) misaligned_q <= 1'b1;
      end
    end
  end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Two instances share all stimulus: dut0 with
// RESET_PC=0 and a distinguishable NOP word, dut1 with RESET_PC=32'h0040_0000.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP0  = 32'h0000_0013;
  localparam logic [31:0] RPC1  = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch;
  logic        ready;
  logic [31:0] rdata;

  logic [31:0] pc4_0, instr_0, count_0;
  logic        busy_0, mis_0;
  logic [31:0] pc4_1, instr_1, count_1;
  logic        busy_1, mis_1;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage_if if0 ();
  fetch_stage_if if1 ();

  assign if0.imem_ready = ready;
  assign if0.imem_rdata = rdata;
  assign if1.imem_ready = ready;
  assign if1.imem_rdata = rdata;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP0)) dut0 (
    .clock            (clock),
    .reset            (reset),
    .StallF           (stall),
    .pc_src_D         (pc_src),
    .pc_branch_D      (branch),
    .imem             (if0.master),
    .pc_plus_four_F   (pc4_0),
    .instruction_F    (instr_0),
    .fetch_busy       (busy_0),
    .fetch_misaligned (mis_0),
    .fetch_count      (count_0)
  );

  fetch_stage #(.RESET_PC(RPC1)) dut1 (
    .clock            (clock),
    .reset            (reset),
    .StallF           (stall),
    .pc_src_D         (pc_src),
    .pc_branch_D      (branch),
    .imem             (if1.master),
    .pc_plus_four_F   (pc4_1),
    .instruction_F    (instr_1),
    .fetch_busy       (busy_1),
    .fetch_misaligned (mis_1),
    .fetch_count      (count_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then step off it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    pc_src = 1'b0;
    branch = 32'h0;
    ready  = 1'b1;
    rdata  = 32'h1111_0000;

    // ---------------- reset state ----------------
    do_reset();
    #1;
    check("rst_req",   {31'b0, if0.imem_req}, 32'd1);
    check("rst_addr",  if0.imem_addr, 32'h0);
    check("rst_pc4",   pc4_0, 32'h4);
    check("rst_busy",  {31'b0, busy_0}, 32'd0);
    check("rst_count", count_0, 32'd0);
    check("rst_mis",   {31'b0, mis_0}, 32'd0);
    check("rst_addr1", if1.imem_addr, RPC1);
    check("rst_pc4_1", pc4_1, RPC1 + 32'd4);

    // ---------------- zero-wait streaming ----------------
    for (int i = 0; i < 4; i++) begin
      check("zw_addr",  if0.imem_addr, 32'(4 * i));
      check("zw_busy",  {31'b0, busy_0}, 32'd0);
      check("zw_count", count_0, 32'(i));
      check("zw_instr", instr_0, rdata);
      cyc();
      #1;
    end
    check("zw_count4", count_0, 32'd4);
    check("zw_addr4",  if0.imem_addr, 32'h10);

    // ---------------- wait states on address 8 ----------------
    do_reset();
    cyc();
    cyc();
    ready = 1'b0;
    #1;
    check("ws_addr0",  if0.imem_addr, 32'h8);
    check("ws_busy0",  {31'b0, busy_0}, 32'd1);
    check("ws_nop0",   instr_0, NOP0);
    check("ws_nop1",   instr_1, 32'h0);
    cyc();
    #1;
    check("ws_addr1",  if0.imem_addr, 32'h8);
    check("ws_busy1",  {31'b0, busy_0}, 32'd1);
    check("ws_nop",    instr_0, NOP0);
    check("ws_count",  count_0, 32'd2);
    cyc();
    ready = 1'b1;
    rdata = 32'h2108_0001;
    #1;
    check("ws_instr",  instr_0, 32'h2108_0001);
    check("ws_pc4",    pc4_0, 32'hC);
    check("ws_busy2",  {31'b0, busy_0}, 32'd0);
    cyc();
    #1;
    check("ws_next",   if0.imem_addr, 32'hC);
    check("ws_cnt3",   count_0, 32'd3);

    // ---------------- stall while word arrives -> HELD ----------------
    do_reset();
    cyc();
    rdata = 32'hAAAA_5555;
    stall = 1'b1;
    #1;
    check("hd_addr",   if0.imem_addr, 32'h4);
    check("hd_instr0", instr_0, 32'hAAAA_5555);
    cyc();
    ready = 1'b0;
    rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hd_req",   {31'b0, if0.imem_req}, 32'd0);
      check("hd_instr", instr_0, 32'hAAAA_5555);
      check("hd_busy",  {31'b0, busy_0}, 32'd0);
      check("hd_count", count_0, 32'd1);
      if (i == 2) stall = 1'b0;
      cyc();
    end
    #1;
    check("hd_rel_addr", if0.imem_addr, 32'h8);
    check("hd_rel_req",  {31'b0, if0.imem_req}, 32'd1);
    check("hd_rel_cnt",  count_0, 32'd2);

    // ---------------- misaligned redirect ----------------
    ready  = 1'b1;
    pc_src = 1'b1;
    branch = 32'h0000_0102;
    cyc();
    pc_src = 1'b0;
    branch = 32'h0;
    #1;
    check("mis_addr", if0.imem_addr, 32'h100);
    check("mis_flag", {31'b0, mis_0}, 32'd1);
    repeat (10) cyc();
    #1;
    check("mis_sticky", {31'b0, mis_0}, 32'd1);
    check("mis_addr10", if0.imem_addr, 32'h128);
    check("mis_count",  count_0, 32'd13);

    // ---------------- PC wrap ----------------
    pc_src = 1'b1;
    branch = 32'hFFFF_FFFF;
    cyc();
    pc_src = 1'b0;
    #1;
    check("wr_addr",  if0.imem_addr, 32'hFFFF_FFFC);
    check("wr_pc4",   pc4_0, 32'h0);
    cyc();
    #1;
    check("wr_addr0", if0.imem_addr, 32'h0);
    check("wr_pc4b",  pc4_0, 32'h4);

    // ---------------- reset mid-request on 32'h40 ----------------
    pc_src = 1'b1;
    branch = 32'h40;
    cyc();
    pc_src = 1'b0;
    ready  = 1'b0;
    #1;
    check("rm_pre_addr", if1.imem_addr, 32'h40);
    check("rm_pre_busy", {31'b0, busy_1}, 32'd1);
    do_reset();
    #1;
    check("rm_addr1",  if1.imem_addr, RPC1);
    check("rm_count1", count_1, 32'd0);
    check("rm_busy1",  {31'b0, busy_1}, 32'd1);
    check("rm_mis0",   {31'b0, mis_0}, 32'd0);
    check("rm_addr0",  if0.imem_addr, 32'h0);

    // ---------------- reset while HELD ----------------
    ready = 1'b1;
    stall = 1'b1;
    rdata = 32'h5A5A_0F0F;
    cyc();
    #1;
    check("rh_held", {31'b0, if0.imem_req}, 32'd0);
    do_reset();
    stall = 1'b0;
    rdata = 32'h0BAD_F00D;
    #1;
    check("rh_req",   {31'b0, if0.imem_req}, 32'd1);
    check("rh_addr",  if0.imem_addr, 32'h0);
    check("rh_instr", instr_0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_stage
